// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from the core data port to a valid/ready memory bus.
// Handles one access at a time: lane steering, alignment and funct3 checks, bus handshake, load extension.
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIM_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CW-1:0] LIM = LIM_I[CW-1:0];

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [1:0]     addr_lo_q, addr_lo_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           misaligned_q, misaligned_d;
    logic           access_fault_q, access_fault_d;
    logic           bus_err_q, bus_err_d;
    logic           mem_req_valid_q, mem_req_valid_d;
    logic           mem_we_q, mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [3:0]     mem_be_q, mem_be_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            is_illegal = f3[2] | (f3 == 3'b011);
        end else begin
            is_illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        end
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   is_misaligned = lo[0];
            2'b10:   is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   lane_rep = {4{w[7:0]}};
            2'b01:   lane_rep = {2{w[15:0]}};
            default: lane_rep = w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [31:0] s;
        s = word >> {lo, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b100:  load_ext = {24'h000000, s[7:0]};
            3'b101:  load_ext = {16'h0000, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    // Next-state and next-output logic; response fields default to zero so they only appear with rsp_valid.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;
        rsp_valid_d     = 1'b0;
        rdata_d         = 32'h0000_0000;
        misaligned_d    = 1'b0;
        access_fault_d  = 1'b0;
        bus_err_d       = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_be_d        = mem_be_q;
        mem_wdata_d     = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    if (is_illegal(req_we, req_funct3)) begin
                        access_fault_d = 1'b1;
                        rsp_valid_d    = 1'b1;
                        state_d        = S_DONE;
                    end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        misaligned_d = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = req_we;
                        mem_addr_d      = {req_addr[31:2], 2'b00};
                        mem_be_d        = byte_en(req_funct3, req_addr[1:0]);
                        mem_wdata_d     = req_we ? lane_rep(req_funct3, req_wdata) : 32'h0000_0000;
                        state_d         = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    mem_req_valid_d = 1'b1;
                    state_d         = S_REQ;
                end
            end
            S_WAIT: begin
                // A response in the final timeout cycle still wins over the timeout.
                if (mem_rsp_valid) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? 32'h0000_0000 : load_ext(funct3_q, addr_lo_q, mem_rsp_rdata);
                    bus_err_d   = mem_rsp_err;
                    state_d     = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == LIM)) begin
                    rsp_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured request fields and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            we_q            <= 1'b0;
            funct3_q        <= 3'b000;
            addr_lo_q       <= 2'b00;
            rsp_valid_q     <= 1'b0;
            rdata_q         <= 32'h0000_0000;
            misaligned_q    <= 1'b0;
            access_fault_q  <= 1'b0;
            bus_err_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0000_0000;
            mem_be_q        <= 4'b0000;
            mem_wdata_q     <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
            rsp_valid_q     <= rsp_valid_d;
            rdata_q         <= rdata_d;
            misaligned_q    <= misaligned_d;
            access_fault_q  <= access_fault_d;
            bus_err_q       <= bus_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_be_q        <= mem_be_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign stall         = ((state_q == S_IDLE) & req_valid) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign rsp_valid     = rsp_valid_q;
    assign rdata         = rdata_q;
    assign misaligned    = misaligned_q;
    assign access_fault  = access_fault_q;
    assign bus_err       = bus_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
